lpc_seq_mul: RTL and testbench

LPC_SEQ_MUL -- requirements
Module: lpc_seq_mul

---
 rtl/lpc_seq_mul.sv | 135 +++++++++++++
 tb/tb_lpc_seq_mul.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_seq_mul.sv
// Sequential radix-4 multiplier: consumes one 2-bit digit of b per cycle.
// Each operand is independently signed or unsigned; the product is exact modulo 2^PW.
module lpc_seq_mul #(
    parameter  int unsigned W  = 8,
    localparam int unsigned PW = 2 * W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          a_signed,
    input  logic          b_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] pp
);

    localparam int unsigned ND = W / 2;
    localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_a;
    logic [W-1:0]  r_b;
    logic          r_b_signed;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_pp;
    logic          r_in_ready;
    logic          r_out_valid;

    state_t        w_state_nxt;
    logic [PW-1:0] w_a_nxt;
    logic [W-1:0]  w_b_nxt;
    logic          w_b_signed_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [PW-1:0] w_acc_nxt;
    logic [PW-1:0] w_pp_nxt;

    logic          w_last;
    logic [PW-1:0] w_term0;
    logic [PW-1:0] w_term1;
    logic [PW-1:0] w_add;
    logic [PW-1:0] w_a_ext;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pp        = r_pp;

    // r_a is pre-shifted by 4^cnt, so the digit's partial product needs no variable shift.
    assign w_last  = (r_cnt == CW'(ND - 1));
    assign w_term0 = r_b[0] ? r_a : '0;
    assign w_term1 = r_b[1] ? {r_a[PW-2:0], 1'b0} : '0;
    // Signed multiplier: the top bit carries weight -2^(W-1), so its term is subtracted.
    assign w_add   = (w_last && r_b_signed) ? (w_term0 - w_term1) : (w_term0 + w_term1);
    assign w_a_ext = a_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_b_signed  <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_pp        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_b_signed  <= w_b_signed_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_pp        <= w_pp_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_b_signed_nxt = r_b_signed;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_pp_nxt       = r_pp;

        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt    = BUSY;
                    w_a_nxt        = w_a_ext;
                    w_b_nxt        = b;
                    w_b_signed_nxt = b_signed;
                    w_cnt_nxt      = '0;
                    w_acc_nxt      = '0;
                end
            end
            BUSY: begin
                w_acc_nxt = r_acc + w_add;
                w_a_nxt   = {r_a[PW-3:0], 2'b00};
                w_b_nxt   = {2'b00, r_b[W-1:2]};
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_pp_nxt    = r_acc + w_add;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_pp_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pp_nxt    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lpc_seq_mul.sv
// Scoreboard bench for lpc_seq_mul: stimulus queues expected products,
// a negedge monitor pops and compares on every handoff and checks latency.
module tb_lpc_seq_mul;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          a_signed;
    logic          b_signed;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] pp;

    lpc_seq_mul #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp        (pp)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [PW-1:0] exp_q[$];
    int            id_q[$];
    int            op_id    = 0;
    int            cyc      = 0;
    int            acc_cyc  = 0;
    int            handoffs = 0;
    logic          prev_ov  = 1'b0;
    logic [PW-1:0] mon_exp;
    int            mon_id;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic xs, input logic ys);
        longint xv;
        longint yv;
        xv = xs ? longint'($signed(x)) : longint'(x);
        yv = ys ? longint'($signed(y)) : longint'(y);
        return PW'(xv * yv);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: accept time, latency at out_valid rise, scoreboard pop on handoff
    always @(negedge clock) begin
        if (!reset) begin
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !prev_ov) chk("latency", PW'(cyc - acc_cyc), PW'(W / 2));
            if (out_valid && out_ready) begin
                handoffs++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_handoff: got pp=0x%0h, expected no result", pp);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_id  = id_q.pop_front();
                    chk($sformatf("pp[op %0d]", mon_id), pp, mon_exp);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_ready: in_ready=0 after 100 cycles, required 1");
        end
    endtask

    // Offer one operand set for exactly one accept edge, then scramble inputs
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tas,
                         input logic tbs, input logic [PW-1:0] exp);
        wait_ready();
        a        = ta;
        b        = tb_;
        a_signed = tas;
        b_signed = tbs;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        id_q.push_back(op_id);
        op_id++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        a_signed = 1'($urandom);
        b_signed = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            id_q.delete();
        end
    endtask

    logic [W-1:0]  da [10] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h7F, 8'h80, 8'hFF, 8'h12, 8'h80};
    logic [W-1:0]  db [10] = '{8'h80, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h34, 8'h7F};
    logic          das[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          dbs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [PW-1:0] dp [10] = '{16'h4000, 16'hFFFF, 16'h00FF, 16'hFE01, 16'hFE02,
                               16'h3F01, 16'h8080, 16'h8080, 16'h03A8, 16'hC080};

    initial begin
        int h0;
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic ras;
        logic rbs;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset_in_ready", PW'(in_ready), PW'(1));
        chk("reset_out_valid", PW'(out_valid), PW'(0));
        chk("reset_pp", pp, '0);

        // Directed products, including the signed/unsigned extremes
        for (int i = 0; i < 10; i++) begin
            issue(da[i], db[i], das[i], dbs[i], dp[i]);
            wait_drain();
            chk($sformatf("idle_after_handoff[%0d]", i), PW'(in_ready), PW'(1));
        end

        // Consumer stall: result must hold while inputs toggle
        out_ready = 1'b0;
        issue(8'h9C, 8'h07, 1'b1, 1'b0, 16'hFD44);
        chk("busy_pp_hidden", pp, '0);
        chk("busy_in_ready", PW'(in_ready), PW'(0));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("stall_reached_done", PW'(out_valid), PW'(1));
        for (int i = 0; i < 10; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = ~in_valid;
            @(posedge clock); #1;
            chk($sformatf("stall_pp[%0d]", i), pp, 16'hFD44);
            chk($sformatf("stall_in_ready[%0d]", i), PW'(in_ready), PW'(0));
            chk($sformatf("stall_out_valid[%0d]", i), PW'(out_valid), PW'(1));
        end
        h0        = handoffs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("handoff_out_valid", PW'(out_valid), PW'(0));
        chk("handoff_no_accept", PW'(in_ready), PW'(1));
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk("handoff_count", PW'(handoffs - h0), PW'(1));
        chk("handoff_still_idle", PW'(in_ready), PW'(1));

        // Reset two cycles into an operation discards it
        wait_ready();
        a        = 8'h11;
        b        = 8'h22;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midop_reset_in_ready", PW'(in_ready), PW'(1));
        chk("midop_reset_out_valid", PW'(out_valid), PW'(0));
        chk("midop_reset_pp", pp, '0);
        h0 = handoffs;
        repeat (8) begin
            @(posedge clock); #1;
        end
        chk("midop_reset_no_result", PW'(handoffs - h0), PW'(0));
        issue(8'h55, 8'hAA, 1'b0, 1'b0, 16'h3872);
        wait_drain();

        // Sweep against the reference model
        for (int i = 0; i < 24; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            ras = 1'($urandom);
            rbs = 1'($urandom);
            issue(ra, rb, ras, rbs, ref_mul(ra, rb, ras, rbs));
            wait_drain();
        end

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", PW'(exp_q.size()), PW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
